// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: PC-sequential icache requests, a QDEPTH-entry {pc, inst} queue,
// valid/ready delivery to decode and redirect flush. Optional same-cycle bypass: FETCHQ_BYPASS_EN.
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

module riscv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(32'h0000_2000),
  parameter int              QDEPTH   = 4,
  parameter int              LOGQ     = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] icache_addr,
  output logic            icache_re,
  input  logic [XLEN-1:0] icache_dout,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [LOGQ:0]   occupancy
);

  // Handshake: a head entry moves to decode in any cycle where out_valid && out_ready are
  // both high at the rising edge; out_valid never depends on out_ready, and a redirect
  // in the same cycle cancels the transfer.

  localparam logic [XLEN-1:0] NOP        = XLEN'(`INSTR_NOP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [LOGQ+1:0] DEPTH_W    = (LOGQ + 2)'(QDEPTH);
  localparam logic [LOGQ:0]   FULL       = (LOGQ + 1)'(QDEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            dead;

  logic [XLEN-1:0] q_pc   [QDEPTH];
  logic [XLEN-1:0] q_inst [QDEPTH];
  logic [LOGQ-1:0] wr_ptr;
  logic [LOGQ-1:0] rd_ptr;
  logic [LOGQ:0]   count;

  logic            resp_fire;
  logic            live_resp;
  logic            head_valid;
  logic [LOGQ+1:0] level;
  logic            push;
  logic            pop;
  logic            bypass;

  assign resp_fire  = inflight && !stall;
  assign live_resp  = resp_fire && !dead;
  assign head_valid = (count != '0);

  // Queued entries plus the outstanding request may never exceed the queue size.
  assign level     = {1'b0, count} + {{(LOGQ + 1){1'b0}}, inflight};
  assign icache_re = reset_n && !stall && !redir_valid && (level < DEPTH_W);

  assign icache_addr = fetch_pc;
  assign occupancy   = count;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = live_resp && !head_valid && !redir_valid;
  assign push   = live_resp && !redir_valid && !(bypass && out_ready);
`else
  assign bypass = 1'b0;
  assign push   = live_resp && !redir_valid;
`endif
  assign pop = head_valid && out_ready && !redir_valid;

  always_comb begin
    out_valid = head_valid;
    out_pc    = '0;
    out_inst  = NOP;
    if (head_valid) begin
      out_pc   = q_pc[rd_ptr];
      out_inst = q_inst[rd_ptr];
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = req_pc;
      out_inst  = icache_dout;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= PC_RESET;
      req_pc   <= '0;
      inflight <= 1'b0;
      dead     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redir_valid) begin
      fetch_pc <= redir_pc & ALIGN_MASK;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      // A response returning this very cycle is simply dropped; one still held off by
      // stall stays outstanding but is marked for discard.
      inflight <= inflight && stall;
      dead     <= inflight && stall;
    end else begin
      if (icache_re) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        req_pc   <= fetch_pc;
        inflight <= 1'b1;
      end else if (resp_fire) begin
        inflight <= 1'b0;
      end
      if (resp_fire) dead <= 1'b0;
      if (push) wr_ptr <= wr_ptr + LOGQ'(1);
      if (pop)  rd_ptr <= rd_ptr + LOGQ'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (LOGQ + 1)'(1);
        2'b01:   count <= count - (LOGQ + 1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only read below count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= req_pc;
      q_inst[wr_ptr] <= icache_dout;
    end
  end

  push_into_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && count == FULL));

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Self-checking bench for riscv_fetch_queue: directed test-plan scenarios with literal
// expectations, then randomized stall/redirect/ready traffic against a queue-level model.
`timescale 1ns/1ps

module tb_riscv_fetch_queue;

`ifdef FETCHQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
  localparam int LAT    = 1;
`else
  localparam bit BYPASS = 1'b0;
  localparam int LAT    = 2;
`endif
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          QDEP = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, redir_valid, out_ready;
  logic [31:0] redir_pc, icache_dout;
  logic [31:0] icache_addr, out_pc, out_inst;
  logic        icache_re, out_valid;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  riscv_fetch_queue #(.XLEN(32), .PC_RESET(32'h0000_2000), .QDEPTH(4), .LOGQ(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
    .stall(stall), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .occupancy(occupancy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: a bijection of the address, so every word is distinct.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] + 16'h1357};
  endfunction

  // ---------------- behavioural model ----------------
  logic [63:0] exp_q[$];          // {pc, inst} entries waiting for decode, head first
  logic [31:0] m_fetch_pc = 32'h2000;
  logic [31:0] m_req_pc   = '0;
  logic        m_inflight = 1'b0;
  logic        m_dead     = 1'b0;
  logic        m_resp, m_live, m_take_byp, m_req;

  function automatic logic exp_re();
    return reset_n && !stall && !redir_valid && ((exp_q.size() + int'(m_inflight)) < QDEP);
  endfunction

  function automatic logic exp_byp();
    return BYPASS && m_inflight && !stall && !m_dead && !redir_valid && exp_q.size() == 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_fetch_pc = 32'h2000;
      m_req_pc   = '0;
      m_inflight = 1'b0;
      m_dead     = 1'b0;
    end else begin
      m_resp = m_inflight && !stall;
      m_req  = exp_re();
      if (redir_valid) begin
        exp_q.delete();
        // only a response not yet returned is still outstanding; it must be thrown away
        m_dead     = m_inflight && stall;
        m_inflight = m_dead;
        m_fetch_pc = {redir_pc[31:2], 2'b00};
      end else begin
        m_live     = m_resp && !m_dead;
        m_take_byp = exp_byp() && out_ready;
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (m_live && !m_take_byp) exp_q.push_back({m_req_pc, mem(m_req_pc)});
        if (m_resp) begin
          m_dead     = 1'b0;
          m_inflight = 1'b0;
        end
        if (m_req) begin
          m_req_pc   = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 32'd4;
          m_inflight = 1'b1;
        end
      end
    end
  end

  // ---------------- compare process (mid-cycle, every cycle) ----------------
  logic        e_valid;
  logic [31:0] e_pc, e_inst;

  always @(negedge clk) begin
    e_valid = (exp_q.size() > 0) || exp_byp();
    e_pc    = 32'h0;
    e_inst  = NOP;
    if (exp_q.size() > 0) begin
      e_pc   = exp_q[0][63:32];
      e_inst = exp_q[0][31:0];
    end else if (e_valid) begin
      e_pc   = m_req_pc;
      e_inst = mem(m_req_pc);
    end
    check("m_icache_re",   32'(icache_re), 32'(exp_re()));
    check("m_icache_addr", icache_addr, m_fetch_pc);
    check("m_occupancy",   32'(occupancy), 32'(exp_q.size()));
    check("m_out_valid",   32'(out_valid), 32'(e_valid));
    check("m_out_pc",      out_pc, e_pc);
    check("m_out_inst",    out_inst, e_inst);
  end

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic r, input logic [31:0] rp, input logic rdy);
    @(posedge clk);
    #1;
    stall       = s;
    redir_valid = r;
    redir_pc    = rp;
    out_ready   = rdy;
    icache_dout = m_inflight ? mem(m_req_pc) : $urandom();
  endtask

  int          first_valid;
  logic [31:0] held_pc;
  int          ready_pct;

  initial begin
    reset_n = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_pc = '0;
    out_ready = 1'b0; icache_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 reset_n = 1'b1; #1;
    check("rst_re",    32'(icache_re), 32'd1);
    check("rst_addr",  icache_addr, 32'h2000);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_occ",   32'(occupancy), 32'd0);
    check("rst_inst",  out_inst, NOP);
    check("rst_pc",    out_pc, 32'h0);

    // Streaming: one instruction per cycle after the fill latency.
    first_valid = -1;
    for (int w = 1; w <= 8; w++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1); #2;
      check("stream_addr", icache_addr, 32'h2000 + 32'(4 * w));
      check("stream_valid", 32'(out_valid), 32'(w >= LAT));
      if (out_valid && first_valid < 0) first_valid = w;
      if (w >= LAT) check("stream_pc", out_pc, 32'h2000 + 32'(4 * (w - LAT)));
    end
    check("first_latency", 32'(first_valid), 32'(LAT));

    // Decode blocked: queue fills to 4 and requests stop.
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    check("sat_occ", 32'(occupancy), 32'd4);
    check("sat_re",  32'(icache_re), 32'd0);

    // Build 3 queued + 1 inflight, then redirect to a misaligned target.
    drive(1'b0, 1'b0, 32'h0, 1'b1); #2;
    check("pop1_occ", 32'(occupancy), 32'd4);
    drive(1'b0, 1'b0, 32'h0, 1'b0); #2;
    check("refill_occ", 32'(occupancy), 32'd3);
    check("refill_re",  32'(icache_re), 32'd1);
    drive(1'b0, 1'b1, 32'h3001, 1'b0); #2;
    check("redir_occ", 32'(occupancy), 32'd3);
    check("redir_re",  32'(icache_re), 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1); #2;
    check("post_redir_occ",  32'(occupancy), 32'd0);
    check("post_redir_addr", icache_addr, 32'h3000);
    check("post_redir_re",   32'(icache_re), 32'd1);
    for (int i = 0; i < 6 && !out_valid; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1); #2;
    end
    check("redir_first_valid", 32'(out_valid), 32'd1);
    check("redir_first_pc",    out_pc, 32'h3000);

    // Stall for 5 cycles: fetch frozen, queue still drains.
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1); #2;
    held_pc = m_fetch_pc;
    check("stall_re", 32'(icache_re), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1); #2;
      check("stall_addr", icache_addr, held_pc);
      check("stall_re",   32'(icache_re), 32'd0);
    end
    check("stall_drained", 32'(occupancy), 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-stream.
    #2 reset_n = 1'b0; #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_occ",   32'(occupancy), 32'd0);
    check("arst_re",    32'(icache_re), 32'd0);
    check("arst_inst",  out_inst, NOP);
    check("arst_pc",    out_pc, 32'h0);
    check("arst_addr",  icache_addr, 32'h2000);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset_n = 1'b1;
    for (int i = 0; i < 6 && !out_valid; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1); #2;
    end
    check("arst_first_valid", 32'(out_valid), 32'd1);
    check("arst_first_pc",    out_pc, 32'h2000);

    // Randomized traffic; decode readiness varies per segment so the queue both fills and drains.
    ready_pct = 70;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) ready_pct = $urandom_range(10, 100);
      drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4, $urandom(),
            $urandom_range(0, 99) < ready_pct);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
